// File: rtl/phys_free_list.sv
// Circular FIFO of free physical register tags between rename and the ROB.
// Up to two returns (commit, then recovery) and one allocation per cycle.
module phys_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_W_P  = 6,
  parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_valid,
  input  logic                       alloc_req,
  output logic                       alloc_valid,
  output logic [PHYS_W_P-1:0]        alloc_preg,
  input  logic                       commit_free_valid,
  input  logic [PHYS_W_P-1:0]        commit_free_preg,
  input  logic                       recover_free_valid,
  input  logic [PHYS_W_P-1:0]        recover_free_preg,
  output logic [$clog2(FL_DEPTH):0]  free_count,
  output logic                       err_overflow
);

  localparam int PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PHYS_W_P-1:0] r_mem [FL_DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;

  logic                w_alloc_fire;
  logic                w_c_ok;
  logic                w_r_ok;
  logic                w_c_acc;
  logic                w_r_acc;
  logic                w_ovf;
  logic [CNT_W-1:0]    w_base;
  logic [CNT_W-1:0]    w_room;
  logic [CNT_W-1:0]    w_npush;
  logic [PTR_W-1:0]    w_r_slot;

  assign alloc_valid  = (r_count != '0);
  assign alloc_preg   = r_mem[r_head];
  assign free_count   = r_count;
  assign err_overflow = r_err;

  assign w_alloc_fire = alloc_req && alloc_valid;

  // Tag 0 is bound to x0 forever and must never re-enter the list.
  assign w_c_ok = commit_free_valid  && (commit_free_preg  != '0);
  assign w_r_ok = recover_free_valid && (recover_free_preg != '0);

  // Room is measured after this cycle's pop; recovery loses out to commit.
  assign w_base  = r_count - CNT_W'(w_alloc_fire);
  assign w_room  = CNT_W'(FL_DEPTH) - w_base;
  assign w_c_acc = w_c_ok && (w_room != '0);
  assign w_r_acc = w_r_ok && (w_c_acc ? (w_room >= CNT_W'(2)) : (w_room != '0));
  assign w_ovf   = (w_c_ok && !w_c_acc) || (w_r_ok && !w_r_acc);

  assign w_npush  = CNT_W'(w_c_acc) + CNT_W'(w_r_acc);
  assign w_r_slot = w_c_acc ? (r_tail + PTR_W'(1)) : r_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) r_mem[i] <= PHYS_W_P'(ARCH_REGS + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(FL_DEPTH);
      r_err   <= 1'b0;
    end else if (flush_valid) begin
      for (int i = 0; i < FL_DEPTH; i++) r_mem[i] <= PHYS_W_P'(ARCH_REGS + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(FL_DEPTH);
      r_err   <= 1'b0;
    end else begin
      if (w_c_acc) r_mem[r_tail] <= commit_free_preg;
      if (w_r_acc) r_mem[w_r_slot] <= recover_free_preg;
      if (w_alloc_fire) r_head <= r_head + PTR_W'(1);
      r_tail  <= r_tail + PTR_W'(w_npush);
      r_count <= w_base + w_npush;
      if (w_ovf) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: vector table for single-cycle behaviour
// plus hand sequences for drain, no-bypass, overflow ordering and async reset.
module tb_phys_free_list;

  logic       clk;
  logic       rst_n;
  logic       flush_valid;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic       commit_free_valid;
  logic [5:0] commit_free_preg;
  logic       recover_free_valid;
  logic [5:0] recover_free_preg;
  logic [5:0] free_count;
  logic       err_overflow;

  int n_checks = 0;
  int n_errors = 0;

  phys_free_list dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_valid        (flush_valid),
    .alloc_req          (alloc_req),
    .alloc_valid        (alloc_valid),
    .alloc_preg         (alloc_preg),
    .commit_free_valid  (commit_free_valid),
    .commit_free_preg   (commit_free_preg),
    .recover_free_valid (recover_free_valid),
    .recover_free_preg  (recover_free_preg),
    .free_count         (free_count),
    .err_overflow       (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       flush;
    logic       areq;
    logic       cv;
    logic [5:0] cp;
    logic       rv;
    logic [5:0] rp;
    logic       e_av;
    logic       chk_preg;
    logic [5:0] e_preg;
    logic [5:0] e_fc;
    logic       e_err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic ar, input logic cv, input logic [5:0] cp,
                       input logic rv, input logic [5:0] rp);
    flush_valid        = fl;
    alloc_req          = ar;
    commit_free_valid  = cv;
    commit_free_preg   = cp;
    recover_free_valid = rv;
    recover_free_preg  = rp;
  endtask

  // Inputs are driven on the falling edge; outputs sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Starting state for the table: list holds only tag 40.
    //            fl ar cv cp  rv rp   av cp? preg fc err
    vecs[0]  = '{0, 0, 1, 41, 0, 0,  1, 1, 40,  2, 0};
    vecs[1]  = '{0, 0, 0, 0,  1, 42, 1, 1, 40,  3, 0};
    vecs[2]  = '{0, 0, 1, 0,  0, 0,  1, 1, 40,  3, 0};
    vecs[3]  = '{0, 0, 0, 0,  1, 0,  1, 1, 40,  3, 0};
    vecs[4]  = '{0, 1, 1, 45, 1, 50, 1, 1, 41,  4, 0};
    vecs[5]  = '{0, 1, 0, 0,  0, 0,  1, 1, 42,  3, 0};
    vecs[6]  = '{0, 1, 0, 0,  0, 0,  1, 1, 45,  2, 0};
    vecs[7]  = '{0, 1, 0, 0,  0, 0,  1, 1, 50,  1, 0};
    vecs[8]  = '{0, 1, 1, 60, 0, 0,  1, 1, 60,  1, 0};
    vecs[9]  = '{0, 1, 0, 0,  0, 0,  0, 0, 0,   0, 0};
    vecs[10] = '{0, 1, 0, 0,  0, 0,  0, 0, 0,   0, 0};
    vecs[11] = '{1, 1, 1, 33, 1, 34, 1, 1, 32, 32, 0};
    vecs[12] = '{0, 1, 0, 0,  0, 0,  1, 1, 33, 31, 0};
    vecs[13] = '{0, 0, 1, 5,  0, 0,  1, 1, 33, 32, 0};
    vecs[14] = '{0, 0, 1, 7,  0, 0,  1, 1, 33, 32, 1};
    vecs[15] = '{0, 0, 0, 0,  0, 0,  1, 1, 33, 32, 1};
    vecs[16] = '{0, 1, 1, 9,  0, 0,  1, 1, 34, 32, 1};
    vecs[17] = '{1, 0, 0, 0,  0, 0,  1, 1, 32, 32, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_av", int'(alloc_valid), 1);
    chk("reset_preg", int'(alloc_preg), 32);
    chk("reset_fc", int'(free_count), 32);
    chk("reset_err", int'(err_overflow), 0);

    // Drain: tags 32..63 in order, then empty.
    for (int i = 0; i < 32; i++) begin
      chk("drain_av", int'(alloc_valid), 1);
      chk("drain_preg", int'(alloc_preg), 32 + i);
      drive(0, 1, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("empty_av", int'(alloc_valid), 0);
    chk("empty_fc", int'(free_count), 0);

    // No bypass: tag pushed into an empty list appears one cycle later.
    drive(0, 1, 1, 40, 0, 0);
    #1;
    chk("nobypass_av_same", int'(alloc_valid), 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("nobypass_av_next", int'(alloc_valid), 1);
    chk("nobypass_preg_next", int'(alloc_preg), 40);
    chk("nobypass_fc_next", int'(free_count), 1);

    foreach (vecs[k]) begin
      drive(vecs[k].flush, vecs[k].areq, vecs[k].cv, vecs[k].cp, vecs[k].rv, vecs[k].rp);
      step();
      chk($sformatf("vec%0d_av", k), int'(alloc_valid), int'(vecs[k].e_av));
      chk($sformatf("vec%0d_fc", k), int'(free_count), int'(vecs[k].e_fc));
      chk($sformatf("vec%0d_err", k), int'(err_overflow), int'(vecs[k].e_err));
      if (vecs[k].chk_preg)
        chk($sformatf("vec%0d_preg", k), int'(alloc_preg), int'(vecs[k].e_preg));
    end

    // Full list, pop plus two pushes: commit 8 kept, recover 9 dropped.
    drive(0, 1, 1, 8, 1, 9);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("dual_ovf_err", int'(err_overflow), 1);
    chk("dual_ovf_fc", int'(free_count), 32);
    chk("dual_ovf_preg", int'(alloc_preg), 33);
    for (int i = 0; i < 31; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("dual_ovf_last_preg", int'(alloc_preg), 8);
    chk("dual_ovf_last_fc", int'(free_count), 1);

    // Async reset in the middle of an allocation burst.
    drive(0, 1, 0, 0, 0, 0);
    step();
    chk("burst_fc", int'(free_count), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_av", int'(alloc_valid), 1);
    chk("async_rst_preg", int'(alloc_preg), 32);
    chk("async_rst_fc", int'(free_count), 32);
    chk("async_rst_err", int'(err_overflow), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_preg", int'(alloc_preg), 32);
    chk("post_rst_fc", int'(free_count), 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
